// File: rtl/cdc_result_collector.sv
// cdc_result_collector
// ---------------------------------------------------------------------------
// Purpose:
//   clk_2-domain consumer of the CDC arithmetic block's result stream.
//   Results are buffered in a small FIFO, then every WIN consecutive results
//   are reduced into one frame (unsigned sum, max, min). The frame is held
//   under a valid/ready handshake until the next stage accepts it.
//
// Ports:
//   clk_2        in   1              sole clock, rising edge
//   rst_n        in   1              synchronous active-low reset
//   in_valid     in   1              result strobe (CDC out_valid)
//   in_data      in   8              result value (CDC out)
//   frame_ready  in   1              downstream accepts the frame
//   frame_valid  out  1              frame outputs valid
//   frame_sum    out  8+log2(WIN)    unsigned sum of WIN results
//   frame_max    out  8              largest result in frame
//   frame_min    out  8              smallest result in frame
//   overflow     out  1              sticky: a result was dropped
//   fifo_level   out  log2(DEPTH)+1  registered FIFO occupancy
// ---------------------------------------------------------------------------

module cdc_result_collector #(
    parameter int WIN   = 4,
    parameter int DEPTH = 4
) (
    input  logic                      clk_2,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    input  logic                      frame_ready,
    output logic                      frame_valid,
    output logic [8+$clog2(WIN)-1:0]  frame_sum,
    output logic [7:0]                frame_max,
    output logic [7:0]                frame_min,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int SW = 8 + $clog2(WIN);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(WIN) + 1;

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIN - 1);

    typedef enum logic {
        S_ACC,
        S_HOLD
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t          state_q, state_d;

    logic [7:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ovf_q, ovf_d;

    logic [SW-1:0]   sum_q, sum_d;
    logic [7:0]      max_q, max_d;
    logic [7:0]      min_q, min_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // -----------------------------------------------------------------------
    // Control strobes
    // -----------------------------------------------------------------------
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            drop;
    logic            pop;
    logic            accept;
    logic            last_pop;
    logic [7:0]      rd_data;

    // Fullness comes from the registered level only: a pop in the same
    // cycle does not make room for an incoming result.
    assign fifo_full  = (level_q == LVL_FULL);
    assign fifo_empty = (level_q == '0);
    assign push       = in_valid && !fifo_full;
    assign drop       = in_valid && fifo_full;
    assign rd_data    = mem_q[rd_ptr_q];
    assign last_pop   = pop && (cnt_q == CNT_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_ACC: begin
                if (last_pop) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    state_d = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        pop         = 1'b0;
        accept      = 1'b0;
        frame_valid = 1'b0;
        unique case (state_q)
            S_ACC: begin
                pop = !fifo_empty;
            end
            S_HOLD: begin
                frame_valid = 1'b1;
                accept      = frame_ready;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO storage (contents need no reset; pointers define validity)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_2) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers, level and sticky overflow
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Frame accumulator
    // -----------------------------------------------------------------------
    always_comb begin
        sum_d = sum_q;
        max_d = max_q;
        min_d = min_q;
        cnt_d = cnt_q;

        if (accept) begin
            sum_d = '0;
            max_d = 8'h00;
            min_d = 8'hFF;
            cnt_d = '0;
        end else if (pop) begin
            sum_d = sum_q + {{(SW-8){1'b0}}, rd_data};
            cnt_d = cnt_q + CW'(1);
            // Strict compares: equal values leave max/min untouched.
            if (rd_data > max_q) begin
                max_d = rd_data;
            end
            if (rd_data < min_q) begin
                min_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            sum_q <= '0;
            max_q <= 8'h00;
            min_q <= 8'hFF;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            max_q <= max_d;
            min_q <= min_d;
            cnt_q <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output drive
    // -----------------------------------------------------------------------
    assign frame_sum  = sum_q;
    assign frame_max  = max_q;
    assign frame_min  = min_q;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_cdc_result_collector.sv
// tb_cdc_result_collector
// Directed bench for cdc_result_collector with a queue-based reference model.

module tb_cdc_result_collector;

    localparam int WIN   = 4;
    localparam int DEPTH = 4;
    localparam int SW    = 8 + $clog2(WIN);

    logic                       clk_2;
    logic                       rst_n;
    logic                       in_valid;
    logic [7:0]                 in_data;
    logic                       frame_ready;
    logic                       frame_valid;
    logic [SW-1:0]              frame_sum;
    logic [7:0]                 frame_max;
    logic [7:0]                 frame_min;
    logic                       overflow;
    logic [$clog2(DEPTH):0]     fifo_level;

    cdc_result_collector #(
        .WIN   (WIN),
        .DEPTH (DEPTH)
    ) dut (
        .clk_2       (clk_2),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_sum   (frame_sum),
        .frame_max   (frame_max),
        .frame_min   (frame_min),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    initial begin
        clk_2 = 1'b0;
        forever #5 clk_2 = ~clk_2;
    end

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: FIFO as a queue, frame as the list of popped values.
    // State here represents the registers after each rising edge.
    // ---------------------------------------------------------------------
    int  m_q[$];
    int  m_acc[$];
    bit  m_hold = 0;
    bit  m_ovf  = 0;
    bit  m_live = 0;

    initial begin
        forever begin
            @(posedge clk_2);
            cyc++;
            if (!rst_n) begin
                m_q.delete();
                m_acc.delete();
                m_hold = 0;
                m_ovf  = 0;
                m_live = 1;
            end else begin
                int  lvl;
                bit  do_pop;
                bit  do_acc;
                bit  do_push;
                lvl     = m_q.size();
                do_pop  = !m_hold && lvl > 0;
                do_acc  = m_hold && frame_ready;
                do_push = in_valid && lvl < DEPTH;
                if (in_valid && lvl == DEPTH) m_ovf = 1;
                if (do_pop) begin
                    m_acc.push_back(m_q.pop_front());
                    if (m_acc.size() == WIN) m_hold = 1;
                end
                if (do_acc) begin
                    m_hold = 0;
                    m_acc.delete();
                end
                if (do_push) m_q.push_back(int'(in_data));
            end
        end
    end

    function automatic int acc_sum();
        int s = 0;
        foreach (m_acc[i]) s += m_acc[i];
        return s;
    endfunction

    function automatic int acc_max();
        int m = 0;
        foreach (m_acc[i]) if (m_acc[i] > m) m = m_acc[i];
        return m;
    endfunction

    function automatic int acc_min();
        int m = 255;
        foreach (m_acc[i]) if (m_acc[i] < m) m = m_acc[i];
        return m;
    endfunction

    // ---------------------------------------------------------------------
    // Per-cycle compare plus a log of frames seen at the DUT outputs.
    // ---------------------------------------------------------------------
    int o_cyc[$];
    int o_sum[$];
    int o_max[$];
    int o_min[$];
    int o_len[$];
    bit prev_fv = 0;

    initial begin
        forever begin
            @(negedge clk_2);
            if (m_live) begin
                check("level", 32'(fifo_level), 32'(m_q.size()));
                check("overflow", 32'(overflow), 32'(m_ovf));
                check("fvalid", 32'(frame_valid), 32'(m_hold));
                if (m_hold || m_acc.size() == 0) begin
                    check("sum", 32'(frame_sum), 32'(acc_sum()));
                    check("max", 32'(frame_max), 32'(acc_max()));
                    check("min", 32'(frame_min), 32'(acc_min()));
                end
            end
            if (frame_valid === 1'b1) begin
                if (!prev_fv) begin
                    o_cyc.push_back(cyc);
                    o_sum.push_back(int'(frame_sum));
                    o_max.push_back(int'(frame_max));
                    o_min.push_back(int'(frame_min));
                    o_len.push_back(1);
                end else begin
                    o_len[o_len.size()-1]++;
                end
                prev_fv = 1;
            end else begin
                prev_fv = 0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (drive #1 after the rising edge)
    // ---------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        in_data  = 8'(v);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic check_frame(input string name, input int idx,
                               input int s, input int mx, input int mn);
        if (idx >= o_sum.size()) begin
            check({name, "_present"}, 32'(o_sum.size()), 32'(idx + 1));
        end else begin
            check({name, "_sum"}, 32'(o_sum[idx]), 32'(s));
            check({name, "_max"}, 32'(o_max[idx]), 32'(mx));
            check({name, "_min"}, 32'(o_min[idx]), 32'(mn));
        end
    endtask

    initial begin
        int t;
        int n0;
        bit found;

        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'h55;
        frame_ready = 1'b0;

        // Reset with in_valid held high: must be ignored.
        tick(2);
        check("rst_fvalid", 32'(frame_valid), 32'd0);
        check("rst_sum", 32'(frame_sum), 32'd0);
        check("rst_max", 32'(frame_max), 32'h00);
        check("rst_min", 32'(frame_min), 32'hFF);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick(1);
        check("post_rst_level", 32'(fifo_level), 32'd0);

        // Basic frame: valid only at t+5, one cycle.
        frame_ready = 1'b1;
        n0 = o_sum.size();
        t  = cyc;
        send(10); send(200); send(3); send(50);
        tick(10);
        check_frame("basic", n0, 263, 200, 3);
        if (n0 < o_cyc.size()) begin
            check("basic_when", 32'(o_cyc[n0]), 32'(t + 5));
            check("basic_len", 32'(o_len[n0]), 32'd1);
        end
        check("basic_count", 32'(o_sum.size()), 32'(n0 + 1));

        // Extremes.
        n0 = o_sum.size();
        repeat (4) send(255);
        tick(8);
        repeat (4) send(0);
        tick(8);
        check_frame("all255", n0, 1020, 255, 255);
        check_frame("all0", n0 + 1, 0, 0, 0);

        // Backpressure and overflow.
        check("pre_bp_ovf", 32'(overflow), 32'd0);
        frame_ready = 1'b0;
        n0 = o_sum.size();
        t  = cyc;
        for (int v = 1; v <= 9; v++) begin
            if (v == 9) check("bp_level_full", 32'(fifo_level), 32'd4);
            send(v);
        end
        check("bp_ovf_set", 32'(overflow), 32'd1);
        tick(3);
        frame_ready = 1'b1;
        tick(10);
        check_frame("bp_f1", n0, 10, 4, 1);
        check_frame("bp_f2", n0 + 1, 26, 8, 5);
        if (n0 + 1 < o_cyc.size()) begin
            check("bp_f1_when", 32'(o_cyc[n0]), 32'(t + 5));
            check("bp_f1_len", 32'(o_len[n0]), 32'd8);
        end
        check("bp_ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-frame discards the partial frame.
        n0 = o_sum.size();
        send(7); send(9);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midrst_ovf_clr", 32'(overflow), 32'd0);
        send(1); send(2); send(3); send(4);
        tick(10);
        check("midrst_count", 32'(o_sum.size()), 32'(n0 + 1));
        check_frame("midrst", n0, 10, 4, 1);

        // Sparse input, accepted two cycles after valid rises.
        frame_ready = 1'b0;
        n0 = o_sum.size();
        send(5); tick(3);
        send(6); tick(3);
        send(7); tick(3);
        send(8);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (frame_valid === 1'b1) begin
                found = 1;
                break;
            end
            tick(1);
        end
        check("sparse_rise", 32'(found), 32'd1);
        tick(2);
        frame_ready = 1'b1;
        tick(1);
        check("sparse_drop", 32'(frame_valid), 32'd0);
        tick(2);
        check_frame("sparse", n0, 26, 8, 5);
        if (n0 < o_len.size()) begin
            check("sparse_len", 32'(o_len[n0]), 32'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
